// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller for the LC-3b 5-stage pipeline: load-use bubbles,
// memory waits and taken-branch redirects, plus the EX/MEM bubble qualifier for forwarding.
module hazard_stall_unit #(
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       de_valid,
    input  logic [2:0]                 de_rs,
    input  logic [2:0]                 de_rt,
    input  logic                       de_uses_rs,
    input  logic                       de_uses_rt,
    input  logic                       de_ex_valid,
    input  logic [3:0]                 de_ex_opcode,
    input  logic [2:0]                 de_ex_dr,
    input  logic                       de_ex_load_regfile,
    input  logic                       imem_resp,
    input  logic                       mem_req,
    input  logic                       mem_done,
    input  logic                       br_taken,
    output logic                       load_pc,
    output logic                       load_if_de,
    output logic                       load_de_ex,
    output logic                       load_ex_mem,
    output logic                       load_mem_wb,
    output logic                       de_ex_bubble,
    output logic                       flush_if_de,
    output logic                       flush_ex_mem,
    output logic                       ex_mem_is_nop,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_LDI = 4'hA;

    typedef enum logic [1:0] {
        RUN            = 2'd0,
        MEM_WAIT       = 2'd1,
        REDIRECT_DRAIN = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic                       nop_q;
    logic [STALL_CNT_WIDTH-1:0] cnt_q;

    logic       is_load;
    logic       dep;
    logic       lu_hazard;
    logic       mem_busy;
    logic       run_eval;
    logic [4:0] ld;
    logic       bub;
    logic       fl_if_de;
    logic       fl_ex_mem;

    always_comb begin
        is_load   = (de_ex_opcode == OP_LDB) || (de_ex_opcode == OP_LDR) || (de_ex_opcode == OP_LDI);
        dep       = (de_uses_rs && (de_rs == de_ex_dr)) || (de_uses_rt && (de_rt == de_ex_dr));
        lu_hazard = de_valid && de_ex_valid && de_ex_load_regfile && is_load && dep;
        mem_busy  = mem_req && !mem_done;
    end

    // ld bit order: {pc, if_de, de_ex, ex_mem, mem_wb}
    always_comb begin
        state_d   = state_q;
        run_eval  = 1'b0;
        ld        = '0;
        bub       = 1'b0;
        fl_if_de  = 1'b0;
        fl_ex_mem = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_busy) state_d = MEM_WAIT;
                else          run_eval = 1'b1;
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    run_eval = 1'b1;
                    state_d  = RUN;
                end
            end
            REDIRECT_DRAIN: begin
                if (!mem_busy) begin
                    // Word returned in this state is the wrong-path fetch: never latch it.
                    ld  = {imem_resp, 4'b0111};
                    bub = 1'b1;
                    if (imem_resp) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Shared by RUN and the mem_done cycle of MEM_WAIT; a redirect with the
        // wrong-path fetch still pending must drain even when leaving MEM_WAIT.
        if (run_eval) begin
            if (br_taken) begin
                ld        = '1;
                bub       = 1'b1;
                fl_if_de  = 1'b1;
                fl_ex_mem = 1'b1;
                if (!imem_resp) state_d = REDIRECT_DRAIN;
            end else if (lu_hazard || !imem_resp) begin
                ld  = 5'b00111;
                bub = 1'b1;
            end else begin
                ld = '1;
            end
        end

        if (!reset_n) begin
            ld        = '0;
            bub       = 1'b0;
            fl_if_de  = 1'b0;
            fl_ex_mem = 1'b0;
        end
    end

    assign load_pc      = ld[4];
    assign load_if_de   = ld[3];
    assign load_de_ex   = ld[2];
    assign load_ex_mem  = ld[1];
    assign load_mem_wb  = ld[0];
    assign de_ex_bubble = bub;
    assign flush_if_de  = fl_if_de;
    assign flush_ex_mem = fl_ex_mem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            nop_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_ex_mem) nop_q <= !de_ex_valid || fl_ex_mem;
            if (!load_pc && (cnt_q != '1)) cnt_q <= cnt_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign ex_mem_is_nop = nop_q;
    assign stall_count   = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and randomized checks of hazard_stall_unit against a rule-level pipeline-control model.
module tb_hazard_stall_unit;

    localparam int unsigned W       = 16;
    localparam int          CNT_MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         de_valid, de_uses_rs, de_uses_rt, de_ex_valid, de_ex_load_regfile;
    logic [2:0]   de_rs, de_rt, de_ex_dr;
    logic [3:0]   de_ex_opcode;
    logic         imem_resp, mem_req, mem_done, br_taken;
    logic         load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb;
    logic         de_ex_bubble, flush_if_de, flush_ex_mem, ex_mem_is_nop;
    logic [W-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: "waiting on memory" and "draining a wrong-path fetch" flags.
    bit         m_memwait, m_drain, m_nop;
    int         m_cnt;
    bit         n_memwait, n_drain;
    logic [4:0] e_ld;
    logic       e_bub, e_fif, e_fem;

    hazard_stall_unit #(.STALL_CNT_WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .de_valid(de_valid), .de_rs(de_rs), .de_rt(de_rt),
        .de_uses_rs(de_uses_rs), .de_uses_rt(de_uses_rt),
        .de_ex_valid(de_ex_valid), .de_ex_opcode(de_ex_opcode), .de_ex_dr(de_ex_dr),
        .de_ex_load_regfile(de_ex_load_regfile),
        .imem_resp(imem_resp), .mem_req(mem_req), .mem_done(mem_done), .br_taken(br_taken),
        .load_pc(load_pc), .load_if_de(load_if_de), .load_de_ex(load_de_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .de_ex_bubble(de_ex_bubble), .flush_if_de(flush_if_de), .flush_ex_mem(flush_ex_mem),
        .ex_mem_is_nop(ex_mem_is_nop), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] loads();
        return 32'({load_pc, load_if_de, load_de_ex, load_ex_mem, load_mem_wb});
    endfunction

    function automatic void model_comb();
        bit is_load, dep, hazard, busy;
        is_load = de_ex_opcode inside {4'h2, 4'h6, 4'hA};
        dep     = (de_uses_rs && de_rs == de_ex_dr) || (de_uses_rt && de_rt == de_ex_dr);
        hazard  = de_valid && de_ex_valid && de_ex_load_regfile && is_load && dep;
        busy    = mem_req && !mem_done;
        e_ld = 5'b00000; e_bub = 0; e_fif = 0; e_fem = 0;
        n_memwait = m_memwait; n_drain = m_drain;
        if (m_memwait && !mem_done) begin
            // whole pipe frozen
        end else if (m_drain) begin
            if (!busy) begin
                e_bub = 1;
                e_ld  = imem_resp ? 5'b10111 : 5'b00111;
                if (imem_resp) n_drain = 0;
            end
        end else if (!m_memwait && busy) begin
            n_memwait = 1;
        end else begin
            n_memwait = 0;
            if (br_taken) begin
                e_ld = 5'b11111; e_bub = 1; e_fif = 1; e_fem = 1;
                n_drain = !imem_resp;
            end else if (hazard || !imem_resp) begin
                e_ld = 5'b00111; e_bub = 1;
            end else begin
                e_ld = 5'b11111;
            end
        end
    endfunction

    function automatic void model_seq();
        if (e_ld[1]) m_nop = !de_ex_valid || e_fem;
        if (!e_ld[4] && m_cnt < CNT_MAX) m_cnt++;
        m_memwait = n_memwait;
        m_drain   = n_drain;
    endfunction

    // Entered just after a negedge with inputs settled; returns at the following negedge.
    task automatic cycle();
        #1;
        model_comb();
        chk("loads", loads(), 32'(e_ld));
        chk("bubble", 32'(de_ex_bubble), 32'(e_bub));
        chk("flush_if_de", 32'(flush_if_de), 32'(e_fif));
        chk("flush_ex_mem", 32'(flush_ex_mem), 32'(e_fem));
        @(posedge clk);
        model_seq();
        #1;
        chk("ex_mem_is_nop", 32'(ex_mem_is_nop), 32'(m_nop));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic idle();
        de_valid = 0; de_rs = 0; de_rt = 0; de_uses_rs = 0; de_uses_rt = 0;
        de_ex_valid = 0; de_ex_opcode = 4'h1; de_ex_dr = 0; de_ex_load_regfile = 0;
        imem_resp = 1; mem_req = 0; mem_done = 0; br_taken = 0;
    endtask

    // Dropped between clock edges so the clear must be asynchronous.
    task automatic do_reset();
        reset_n = 0;
        #1;
        chk("rst_loads", loads(), 32'd0);
        chk("rst_bubble", 32'(de_ex_bubble), 32'd0);
        chk("rst_flushes", 32'({flush_if_de, flush_ex_mem}), 32'd0);
        chk("rst_nop", 32'(ex_mem_is_nop), 32'd1);
        chk("rst_count", 32'(stall_count), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_count_hold", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset_n = 1;
        m_memwait = 0; m_drain = 0; m_nop = 1; m_cnt = 0;
    endtask

    task automatic ldr_then(input logic [2:0] rs, input logic [2:0] rt);
        idle();
        de_valid = 1; de_rs = rs; de_rt = rt; de_uses_rs = 1; de_uses_rt = 1;
        de_ex_valid = 1; de_ex_opcode = 4'h6; de_ex_dr = 3'd2; de_ex_load_regfile = 1;
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();

        // Dependent load-use: one bubble
        ldr_then(3'd2, 3'd1);
        #1;
        chk("lu_pc", 32'(load_pc), 32'd0);
        chk("lu_ifde", 32'(load_if_de), 32'd0);
        chk("lu_bubble", 32'(de_ex_bubble), 32'd1);
        cycle();
        chk("lu_count", 32'(stall_count), 32'd1);
        de_ex_valid = 0;
        #1;
        chk("lu_resume", loads(), 32'h1F);
        cycle();
        chk("lu_nop_next", 32'(ex_mem_is_nop), 32'd1);
        chk("lu_count_next", 32'(stall_count), 32'd1);

        // Independent instruction: no stall
        do_reset();
        ldr_then(3'd4, 3'd1);
        #1;
        chk("nodep_loads", loads(), 32'h1F);
        cycle();
        cycle();
        chk("nodep_nop", 32'(ex_mem_is_nop), 32'd0);
        chk("nodep_count", 32'(stall_count), 32'd0);

        // LDI with a five-cycle data wait
        do_reset();
        idle();
        de_ex_opcode = 4'hA; mem_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("memwait_frozen", loads(), 32'd0);
            cycle();
        end
        mem_done = 1;
        #1;
        chk("memdone_resume", loads(), 32'h1F);
        cycle();
        chk("memwait_count", 32'(stall_count), 32'd5);

        // Taken branch with wrong-path fetch outstanding
        do_reset();
        idle();
        br_taken = 1; imem_resp = 0;
        #1;
        chk("br_loads", loads(), 32'h1F);
        chk("br_flushes", 32'({flush_if_de, de_ex_bubble, flush_ex_mem}), 32'h7);
        cycle();
        br_taken = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("drain_front", 32'({load_pc, load_if_de}), 32'd0);
            chk("drain_bubble", 32'(de_ex_bubble), 32'd1);
            cycle();
        end
        imem_resp = 1;
        #1;
        chk("drain_discard", 32'({load_pc, load_if_de}), 32'h2);
        cycle();
        #1;
        chk("target_fetch", loads(), 32'h1F);
        cycle();
        chk("drain_count", 32'(stall_count), 32'd2);

        // Redirect outranks a simultaneous load-use hazard
        do_reset();
        ldr_then(3'd2, 3'd2);
        br_taken = 1;
        #1;
        chk("brlu_flush_if_de", 32'(flush_if_de), 32'd1);
        chk("brlu_flush_ex_mem", 32'(flush_ex_mem), 32'd1);
        chk("brlu_pc", 32'(load_pc), 32'd1);
        cycle();
        chk("brlu_count", 32'(stall_count), 32'd0);
        chk("brlu_nop", 32'(ex_mem_is_nop), 32'd1);

        // Reset in the middle of a memory wait
        idle();
        mem_req = 1;
        cycle();
        cycle();
        #3;
        do_reset();
        idle();
        #1;
        chk("post_rst_run", loads(), 32'h1F);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            de_valid           = $urandom_range(0, 3) != 0;
            de_rs              = 3'($urandom_range(0, 3));
            de_rt              = 3'($urandom_range(0, 3));
            de_uses_rs         = $urandom_range(0, 1) == 1;
            de_uses_rt         = $urandom_range(0, 1) == 1;
            de_ex_valid        = $urandom_range(0, 3) != 0;
            de_ex_opcode       = ($urandom_range(0, 1) == 1) ? 4'h6 : 4'($urandom_range(0, 15));
            de_ex_dr           = 3'($urandom_range(0, 3));
            de_ex_load_regfile = $urandom_range(0, 3) != 0;
            imem_resp          = $urandom_range(0, 3) != 0;
            mem_req            = $urandom_range(0, 4) == 0;
            mem_done           = $urandom_range(0, 2) == 0;
            br_taken           = $urandom_range(0, 7) == 0;
            cycle();
        end

        // Saturating stall counter
        do_reset();
        idle();
        imem_resp = 0;
        for (int i = 0; i < 65540; i++) cycle();
        chk("sat_count", 32'(stall_count), 32'hFFFF);
        cycle();
        chk("sat_hold", 32'(stall_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
